// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types: parity modes, TX state encoding, baud helper.
// Revision: 1.0
// ============================================================================
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per bit period, truncated.
  function automatic int baud_count(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with push/pop, full/empty flags and occupancy.
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign full     = (r_level == c_depth);
  assign empty    = (r_level == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];
  assign level    = r_level;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : FIFO-backed UART transmitter, configurable width/parity/stop bits.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_done,
  output logic                          tx_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rs232_tx
);

  localparam int c_baud_cnt = baud_count(CLK_FREQ, BAUD_RATE);
  localparam int c_cnt_w    = (c_baud_cnt > 1) ? $clog2(c_baud_cnt) : 1;
  localparam int c_idx_w    = $clog2(DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_baud_cnt - 1);
  localparam logic [c_idx_w-1:0] c_data_last = c_idx_w'(DATA_BITS - 1);
  localparam logic [c_idx_w-1:0] c_stop_last = c_idx_w'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
      c_baud_cnt < 1) begin : g_param_check
    $fatal(1, "uart_tx_fifo: illegal parameter value");
  end

  tx_state_t              r_state, w_state_nxt;
  logic [c_cnt_w-1:0]     r_baud_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]     r_bit_idx, w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_parity, w_par_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_load;
  logic                   w_bit_end;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_head_par;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (w_load),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign w_bit_end  = (r_baud_cnt == c_baud_last);
  assign w_head_par = (PARITY == PAR_ODD) ? ~(^w_head) : (^w_head);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_cnt_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_baud_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_parity;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;

    if (r_state != ST_IDLE) w_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;

    case (r_state)
      ST_IDLE: w_load = !w_empty;
      ST_START: if (w_bit_end) begin
        w_state_nxt = ST_DATA;
        w_idx_nxt   = '0;
        w_tx_nxt    = r_shift[0];
      end
      ST_DATA: if (w_bit_end) begin
        w_shift_nxt = r_shift >> 1;
        w_tx_nxt    = r_shift[1];
        w_idx_nxt   = r_bit_idx + 1'b1;
        if (r_bit_idx == c_data_last) begin
          w_idx_nxt = '0;
          if (PARITY != PAR_NONE) begin
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_parity;
          end else begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      ST_PARITY: if (w_bit_end) begin
        w_state_nxt = ST_STOP;
        w_idx_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
      ST_STOP: if (w_bit_end) begin
        w_idx_nxt = r_bit_idx + 1'b1;
        if (r_bit_idx == c_stop_last) begin
          w_done_nxt  = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
          w_load      = !w_empty;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Popping the head overrides the stop-exit path so frames run back-to-back.
    if (w_load) begin
      w_state_nxt = ST_START;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_shift_nxt = w_head;
      w_par_nxt   = w_head_par;
      w_tx_nxt    = 1'b0;
    end
  end

  assign tx_ready = !w_full;
  assign tx_done  = r_done;
  assign tx_state = (r_state != ST_IDLE);
  assign rs232_tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Self-checking bench for uart_tx_fifo against a frame-level model.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int DATA_BITS  = 8;
  localparam int PARITY     = 1;
  localparam int STOP_BITS  = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD  = CLK_FREQ / BAUD_RATE;
  localparam int NBITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int FLEN  = NBITS * BAUD;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  logic                 clk_in;
  logic                 rst_in;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 tx_state;
  logic [LW-1:0]        fifo_level;
  logic                 rs232_tx;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 0;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY),
    .STOP_BITS  (STOP_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_state   (tx_state),
    .fifo_level (fifo_level),
    .rs232_tx   (rs232_tx)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h time=%0t", name, got, exp, $time);
    end
  endtask

  // Bit i of the result is the i-th bit placed on the line.
  function automatic logic [NBITS-1:0] frame_of(input logic [DATA_BITS-1:0] d);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_BITS:1] = d;
    if (PARITY == 1)      f[DATA_BITS+1] = ~(^d);
    else if (PARITY == 2) f[DATA_BITS+1] = ^d;
    return f;
  endfunction

  // Reference model: word queue plus a position counter into the current frame.
  logic [DATA_BITS-1:0] m_q[$];
  logic [NBITS-1:0]     m_frame = '1;
  bit                   m_busy = 0;
  int                   m_t = 0;
  bit                   m_done = 0;
  bit                   m_ready_pre;
  bit                   m_fend;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_q.delete();
      m_busy = 0;
      m_t    = 0;
      m_done = 0;
    end else begin
      m_ready_pre = (m_q.size() < FIFO_DEPTH);
      m_fend      = m_busy && (m_t == FLEN - 1);
      m_done      = m_fend;
      if (m_q.size() > 0 && (!m_busy || m_fend)) begin
        m_frame = frame_of(m_q.pop_front());
        m_busy  = 1;
        m_t     = 0;
      end else if (m_fend) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_t++;
      end
      if (tx_valid && m_ready_pre) m_q.push_back(tx_data);
    end
  end

  logic exp_tx;
  always @(negedge clk_in) begin
    if (chk_en) begin
      exp_tx = m_busy ? m_frame[m_t / BAUD] : 1'b1;
      check("cmp_rs232_tx",   rs232_tx,   exp_tx);
      check("cmp_tx_state",   tx_state,   m_busy);
      check("cmp_tx_done",    tx_done,    m_done);
      check("cmp_fifo_level", fifo_level, m_q.size());
      check("cmp_tx_ready",   tx_ready,   m_q.size() < FIFO_DEPTH);
    end
  end

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && (m_busy || m_q.size() != 0); i++) @(negedge clk_in);
    check("drain_timeout", m_busy || m_q.size() != 0, 0);
  endtask

  task automatic send_and_capture(input logic [DATA_BITS-1:0] d,
                                  output logic [NBITS-1:0] bits,
                                  output int done_idx, output int done_cnt,
                                  output int state_hi);
    @(negedge clk_in);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk_in);
    tx_valid = 1'b0;
    bits = '0;
    done_idx = -1;
    done_cnt = 0;
    state_hi = 0;
    for (int i = 0; i < FLEN + 5; i++) begin
      @(negedge clk_in);
      if ((i % BAUD) == BAUD / 2 && (i / BAUD) < NBITS) bits[i / BAUD] = rs232_tx;
      if (tx_done) begin
        done_cnt++;
        done_idx = i;
      end
      if (tx_state) state_hi++;
    end
  endtask

  logic [NBITS-1:0] cap_bits;
  int cap_idx, cap_cnt, cap_hi, acc, hi_cnt, done_cnt;

  initial begin
    rst_in   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    #1 rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_rs232_tx",   rs232_tx,   1);
    check("reset_tx_ready",   tx_ready,   1);
    check("reset_fifo_level", fifo_level, 0);
    check("reset_tx_state",   tx_state,   0);
    check("reset_tx_done",    tx_done,    0);
    chk_en = 1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Single frames with hand-computed line patterns (odd parity, 2 stop bits).
    send_and_capture(8'hAA, cap_bits, cap_idx, cap_cnt, cap_hi);
    check("frame_aa_bits",   cap_bits, 12'hF54);
    check("frame_aa_doneat", cap_idx,  FLEN);
    check("frame_aa_ndone",  cap_cnt,  1);
    check("frame_aa_busy",   cap_hi,   FLEN);
    send_and_capture(8'h01, cap_bits, cap_idx, cap_cnt, cap_hi);
    check("frame_01_bits",   cap_bits, 12'hC02);
    check("frame_01_ndone",  cap_cnt,  1);

    // Three-word burst: continuous line activity, three done pulses.
    wait_idle(8 * FLEN);
    @(negedge clk_in); tx_valid = 1'b1; tx_data = 8'h11;
    @(negedge clk_in); tx_data = 8'h22;
    @(negedge clk_in); tx_data = 8'h33;
    @(negedge clk_in); tx_valid = 1'b0;
    check("burst_level", fifo_level, 2);
    hi_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 3 * FLEN + 10; i++) begin
      if (tx_state) hi_cnt++;
      if (tx_done)  done_cnt++;
      @(negedge clk_in);
    end
    check("burst_ndone",   done_cnt, 3);
    check("burst_busy_hi", hi_cnt,   3 * FLEN - 1);

    // Hold tx_valid from idle: one word popped plus a full FIFO are accepted.
    wait_idle(8 * FLEN);
    @(negedge clk_in);
    tx_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      tx_data = DATA_BITS'($urandom);
      if (tx_ready) acc++;
      @(negedge clk_in);
    end
    check("full_accepted", acc, FIFO_DEPTH + 1);
    check("full_level",    fifo_level, FIFO_DEPTH);
    check("full_ready",    tx_ready, 0);
    tx_data = 8'h5A;
    for (int k = 0; k < 2 * FLEN && !tx_ready; k++) @(negedge clk_in);
    check("held_word_ready", tx_ready, 1);
    @(negedge clk_in);
    tx_valid = 1'b0;
    wait_idle(8 * FLEN);

    // Asynchronous reset in the data phase of a burst.
    @(negedge clk_in); tx_valid = 1'b1; tx_data = 8'hA1;
    @(negedge clk_in); tx_data = 8'hB2;
    @(negedge clk_in); tx_data = 8'hC3;
    @(negedge clk_in); tx_valid = 1'b0;
    repeat (4 * BAUD) @(negedge clk_in);
    check("pre_rst_state", tx_state, 1);
    check("pre_rst_line",  rs232_tx, 0);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    check("rst_async_line",  rs232_tx,   1);
    check("rst_async_level", fifo_level, 0);
    check("rst_async_state", tx_state,   0);
    check("rst_async_done",  tx_done,    0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    send_and_capture(8'h3C, cap_bits, cap_idx, cap_cnt, cap_hi);
    check("post_rst_bits",   cap_bits, 12'hE78);
    check("post_rst_doneat", cap_idx,  FLEN);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_in);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = DATA_BITS'($urandom);
    end
    @(negedge clk_in);
    tx_valid = 1'b0;
    wait_idle(8 * FLEN);
    repeat (3) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
